// File: rtl/spi_byte_master.sv
// Single-byte SPI master (mode 0), MSB first, driven by a CPU register write.
// The end of the CPU write strobe starts a transfer; status and RX byte read back on dataout.
module spi_byte_master #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic        sysclk,
    input  logic        rst_n,
    input  logic [15:0] datain,
    input  logic        wrh_n,
    output logic [15:0] dataout,
    output logic        spi_sck,
    output logic        spi_mosi,
    input  logic        spi_miso,
    output logic        spi_cs_n
);

    localparam int unsigned DIV_W  = 8;
    localparam int unsigned BIT_W  = 3;
    localparam int unsigned BYTE_W = 8;
    localparam logic [DIV_W-1:0] DIV_RELOAD = DIV_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_PENULT = BIT_W'(6);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOW  = 2'd1,
        ST_HIGH = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    logic wrh_meta;
    logic wrh_sync;
    logic wrh_prev;
    logic cmd_c;
    logic div_zero_c;
    logic unused_c;

    logic [DIV_W-1:0]  div_cnt,  div_cnt_nxt;
    logic [BIT_W-1:0]  bit_cnt,  bit_cnt_nxt;
    logic              bit_last, bit_last_nxt;
    logic [BYTE_W-1:0] tx_sh,    tx_sh_nxt;
    logic [BYTE_W-1:0] rx_sh,    rx_sh_nxt;
    logic [BYTE_W-1:0] rx_byte,  rx_byte_nxt;
    logic              busy,     busy_nxt;
    logic              done,     done_nxt;
    logic              cs_n_nxt;
    logic              sck_nxt;
    logic              mosi_nxt;

    // Write strobe synchroniser; a command is the 0->1 edge (end of CPU write)
    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            wrh_meta <= 1'b1;
            wrh_sync <= 1'b1;
            wrh_prev <= 1'b1;
        end else begin
            wrh_meta <= wrh_n;
            wrh_sync <= wrh_meta;
            wrh_prev <= wrh_sync;
        end
    end

    assign cmd_c      = wrh_sync & ~wrh_prev;
    assign div_zero_c = (div_cnt == '0);
    assign unused_c   = ^datain[14:9];

    // State register
    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (cmd_c && datain[15]) begin
                    state_nxt = ST_LOW;
                end
            end
            ST_LOW: begin
                if (div_zero_c) begin
                    state_nxt = ST_HIGH;
                end
            end
            ST_HIGH: begin
                if (div_zero_c) begin
                    state_nxt = bit_last ? ST_IDLE : ST_LOW;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Output / datapath next values; commands are only honoured in IDLE
    always_comb begin
        div_cnt_nxt  = div_cnt;
        bit_cnt_nxt  = bit_cnt;
        bit_last_nxt = bit_last;
        tx_sh_nxt    = tx_sh;
        rx_sh_nxt    = rx_sh;
        rx_byte_nxt  = rx_byte;
        busy_nxt     = busy;
        done_nxt     = done;
        cs_n_nxt     = spi_cs_n;
        sck_nxt      = spi_sck;
        mosi_nxt     = spi_mosi;
        case (state)
            ST_IDLE: begin
                sck_nxt = 1'b0;
                if (cmd_c) begin
                    cs_n_nxt = ~datain[8];
                    if (datain[15]) begin
                        tx_sh_nxt    = datain[7:0];
                        mosi_nxt     = datain[7];
                        div_cnt_nxt  = DIV_RELOAD;
                        bit_cnt_nxt  = '0;
                        bit_last_nxt = 1'b0;
                        busy_nxt     = 1'b1;
                        done_nxt     = 1'b0;
                    end
                end
            end
            ST_LOW: begin
                if (div_zero_c) begin
                    // Rising SCK: capture MISO
                    div_cnt_nxt = DIV_RELOAD;
                    sck_nxt     = 1'b1;
                    rx_sh_nxt   = {rx_sh[BYTE_W-2:0], spi_miso};
                end else begin
                    div_cnt_nxt = div_cnt - DIV_W'(1);
                end
            end
            ST_HIGH: begin
                if (div_zero_c) begin
                    // Falling SCK: advance to next bit or finish
                    div_cnt_nxt  = DIV_RELOAD;
                    sck_nxt      = 1'b0;
                    tx_sh_nxt    = {tx_sh[BYTE_W-2:0], 1'b0};
                    mosi_nxt     = tx_sh[BYTE_W-2];
                    bit_cnt_nxt  = bit_cnt + BIT_W'(1);
                    bit_last_nxt = (bit_cnt == BIT_PENULT);
                    if (bit_last) begin
                        rx_byte_nxt = rx_sh;
                        busy_nxt    = 1'b0;
                        done_nxt    = 1'b1;
                    end
                end else begin
                    div_cnt_nxt = div_cnt - DIV_W'(1);
                end
            end
            default: begin
                sck_nxt = 1'b0;
            end
        endcase
    end

    // Datapath and output registers
    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt  <= '0;
            bit_cnt  <= '0;
            bit_last <= 1'b0;
            tx_sh    <= '0;
            rx_sh    <= '0;
            rx_byte  <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            spi_cs_n <= 1'b1;
            spi_sck  <= 1'b0;
            spi_mosi <= 1'b0;
        end else begin
            div_cnt  <= div_cnt_nxt;
            bit_cnt  <= bit_cnt_nxt;
            bit_last <= bit_last_nxt;
            tx_sh    <= tx_sh_nxt;
            rx_sh    <= rx_sh_nxt;
            rx_byte  <= rx_byte_nxt;
            busy     <= busy_nxt;
            done     <= done_nxt;
            spi_cs_n <= cs_n_nxt;
            spi_sck  <= sck_nxt;
            spi_mosi <= mosi_nxt;
        end
    end

    assign dataout = {busy, done, 5'b0_0000, ~spi_cs_n, rx_byte};

endmodule

// File: tb/tb_spi_byte_master.sv
// Bench for spi_byte_master: two instances (CLK_DIV 4 and 1) checked every cycle
// against a transfer-timeline model, plus hand-computed end-of-transfer values.
module tb_spi_byte_master;

    localparam int DIV0 = 4;
    localparam int DIV1 = 1;

    logic        sysclk = 1'b0;
    logic        rst_n  = 1'b0;
    logic [15:0] datain [2];
    logic        wrh_n  [2];
    logic [15:0] dout   [2];
    logic        sck    [2];
    logic        mosi   [2];
    logic        miso   [2];
    logic        cs_n   [2];
    logic        loop   [2];
    logic        fix    [2];

    always #5 sysclk = ~sysclk;

    assign miso[0] = loop[0] ? mosi[0] : fix[0];
    assign miso[1] = loop[1] ? mosi[1] : fix[1];

    spi_byte_master #(.CLK_DIV(DIV0)) u_dut0 (
        .sysclk(sysclk), .rst_n(rst_n), .datain(datain[0]), .wrh_n(wrh_n[0]),
        .dataout(dout[0]), .spi_sck(sck[0]), .spi_mosi(mosi[0]),
        .spi_miso(miso[0]), .spi_cs_n(cs_n[0])
    );

    spi_byte_master #(.CLK_DIV(DIV1)) u_dut1 (
        .sysclk(sysclk), .rst_n(rst_n), .datain(datain[1]), .wrh_n(wrh_n[1]),
        .dataout(dout[1]), .spi_sck(sck[1]), .spi_mosi(mosi[1]),
        .spi_miso(miso[1]), .spi_cs_n(cs_n[1])
    );

    int n_checks = 0;
    int n_fail   = 0;
    logic chk_en = 1'b0;

    task automatic check(input string name, input int d, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d: got %h expected %h at %0t", name, d, act, exp, $time);
        end
    endtask

    function automatic int div_of(input int d);
        return (d == 0) ? DIV0 : DIV1;
    endfunction

    // Edge counter and command schedule (edge index at which the DUT recognises the write)
    int unsigned cyc = 0;
    int unsigned cmd_edge [2] = '{0, 0};
    logic [15:0] cmd_data [2] = '{16'h0, 16'h0};

    always @(posedge sysclk) cyc <= cyc + 1;

    // Model: m_k is the cycle index within a transfer (1..16*DIV), 0 when idle
    int          m_k     [2];
    logic        m_done  [2];
    logic        m_cs    [2];
    logic [7:0]  m_tx    [2];
    logic [7:0]  m_rxexp [2];
    logic [7:0]  m_rx    [2];
    logic        m_fresh [2];

    always @(posedge sysclk or negedge rst_n) begin : model
        int nk;
        logic nd, ncs, nfresh, was_busy;
        logic [7:0] ntx, nrxe, nrx;
        if (!rst_n) begin
            for (int d = 0; d < 2; d++) begin
                m_k[d] <= 0; m_done[d] <= 1'b0; m_cs[d] <= 1'b0;
                m_tx[d] <= 8'h00; m_rxexp[d] <= 8'h00; m_rx[d] <= 8'h00; m_fresh[d] <= 1'b1;
            end
        end else begin
            for (int d = 0; d < 2; d++) begin
                nk = m_k[d]; nd = m_done[d]; ncs = m_cs[d]; nfresh = m_fresh[d];
                ntx = m_tx[d]; nrxe = m_rxexp[d]; nrx = m_rx[d];
                was_busy = (nk != 0);
                if (was_busy) begin
                    if (nk == 16 * div_of(d)) begin
                        nk = 0; nd = 1'b1; nrx = nrxe;
                    end else begin
                        nk = nk + 1;
                    end
                end
                if ((cyc + 1 == cmd_edge[d]) && !was_busy) begin
                    ncs = cmd_data[d][8];
                    if (cmd_data[d][15]) begin
                        nk = 1; nd = 1'b0; nfresh = 1'b0;
                        ntx = cmd_data[d][7:0];
                        nrxe = loop[d] ? cmd_data[d][7:0] : {8{fix[d]}};
                    end
                end
                m_k[d] <= nk; m_done[d] <= nd; m_cs[d] <= ncs; m_fresh[d] <= nfresh;
                m_tx[d] <= ntx; m_rxexp[d] <= nrxe; m_rx[d] <= nrx;
            end
        end
    end

    // Per-cycle comparison against the model
    always @(negedge sysclk) begin : compare
        logic eb, es, ec, em;
        int bi;
        if (chk_en) begin
            for (int d = 0; d < 2; d++) begin
                eb = (m_k[d] != 0);
                es = eb && ((((m_k[d] - 1) / div_of(d)) % 2) == 1);
                ec = ~m_cs[d];
                check("dataout", d, dout[d], {eb, m_done[d], 5'b0, m_cs[d], m_rx[d]});
                check("sck", d, 16'(sck[d]), 16'(es));
                check("cs_n", d, 16'(cs_n[d]), 16'(ec));
                if (eb) begin
                    bi = (m_k[d] - 1) / (2 * div_of(d));
                    em = m_tx[d][7 - bi];
                    check("mosi", d, 16'(mosi[d]), 16'(em));
                end else if (m_fresh[d]) begin
                    check("mosi_idle", d, 16'(mosi[d]), 16'h0000);
                end
            end
        end
    end

    // Activity monitor: SCK rises, MOSI at rises, BUSY cycles, rise spacing
    int unsigned neg_cnt = 0;
    int unsigned rises     [2] = '{0, 0};
    int unsigned busy_cyc  [2] = '{0, 0};
    int unsigned last_rise [2] = '{0, 0};
    int unsigned last_gap  [2] = '{0, 0};
    logic [7:0]  hist      [2] = '{8'h00, 8'h00};
    logic        sck_prev  [2] = '{1'b0, 1'b0};

    always @(negedge sysclk) begin
        neg_cnt <= neg_cnt + 1;
        for (int d = 0; d < 2; d++) begin
            if (sck[d] && !sck_prev[d]) begin
                rises[d]     <= rises[d] + 1;
                hist[d]      <= {hist[d][6:0], mosi[d]};
                last_gap[d]  <= neg_cnt - last_rise[d];
                last_rise[d] <= neg_cnt;
            end
            sck_prev[d] <= sck[d];
            if (dout[d][15]) busy_cyc[d] <= busy_cyc[d] + 1;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge sysclk);
        #1;
    endtask

    task automatic wr(input int d, input logic [15:0] v);
        datain[d] = v;
        wrh_n[d]  = 1'b0;
        tick(4);
        wrh_n[d]    = 1'b1;
        cmd_data[d] = v;
        cmd_edge[d] = cyc + 3;
        tick(4);
    endtask

    task automatic wait_idle(input int d);
        int n;
        n = 0;
        while (dout[d][15] && n < 2000) begin
            tick(1);
            n++;
        end
        check("idle_timeout", d, 16'(dout[d][15]), 16'h0000);
    endtask

    task automatic wait_rises(input int d, input int unsigned base, input int unsigned cnt);
        int n;
        n = 0;
        while ((rises[d] - base) < cnt && n < 1000) begin
            tick(1);
            n++;
        end
        check("rise_timeout", d, 16'(n < 1000), 16'h0001);
    endtask

    initial begin : main
        int unsigned r0, r1, b0;
        for (int d = 0; d < 2; d++) begin
            datain[d] = 16'h0000; wrh_n[d] = 1'b1; loop[d] = 1'b1; fix[d] = 1'b0;
        end
        rst_n = 1'b0;
        tick(3);
        chk_en = 1'b1;
        tick(2);

        // Reset values
        for (int d = 0; d < 2; d++) begin
            check("rst_dout", d, dout[d], 16'h0000);
            check("rst_cs_n", d, 16'(cs_n[d]), 16'h0001);
            check("rst_sck",  d, 16'(sck[d]),  16'h0000);
            check("rst_mosi", d, 16'(mosi[d]), 16'h0000);
        end
        rst_n = 1'b1;
        r0 = rises[0]; r1 = rises[1];
        tick(100);
        check("rst_no_sck", 0, 16'(rises[0] - r0), 16'd0);
        check("rst_no_sck", 1, 16'(rises[1] - r1), 16'd0);

        // Loopback, CLK_DIV=4
        loop[0] = 1'b1;
        r0 = rises[0]; b0 = busy_cyc[0];
        wr(0, 16'h81A5);
        check("lb_cs_n", 0, 16'(cs_n[0]), 16'h0000);
        wait_idle(0);
        tick(2);
        check("lb_rises", 0, 16'(rises[0] - r0), 16'd8);
        check("lb_mosi_bits", 0, {8'h00, hist[0]}, 16'h00A5);
        check("lb_busy_len", 0, 16'(busy_cyc[0] - b0), 16'd64);
        check("lb_gap", 0, 16'(last_gap[0]), 16'd8);
        check("lb_dout", 0, dout[0], 16'h41A5);

        // Fixed MISO=1, then release CS
        loop[0] = 1'b0; fix[0] = 1'b1;
        wr(0, 16'h813C);
        wait_idle(0);
        tick(1);
        check("fix_dout", 0, dout[0], 16'h41FF);
        r0 = rises[0];
        wr(0, 16'h0000);
        check("rel_cs_n", 0, 16'(cs_n[0]), 16'h0001);
        tick(20);
        check("rel_no_sck", 0, 16'(rises[0] - r0), 16'd0);
        check("rel_dout", 0, dout[0], 16'h40FF);

        // Write while busy is ignored
        loop[0] = 1'b1;
        r0 = rises[0];
        wr(0, 16'h81C3);
        wait_rises(0, r0, 3);
        wr(0, 16'h0000);
        check("busy_wr_cs_n", 0, 16'(cs_n[0]), 16'h0000);
        wait_idle(0);
        tick(1);
        check("busy_wr_dout", 0, dout[0], 16'h41C3);
        check("busy_wr_rises", 0, 16'(rises[0] - r0), 16'd8);
        wr(0, 16'h8155);
        wait_idle(0);
        tick(1);
        check("after_busy_dout", 0, dout[0], 16'h4155);

        // Reset mid-transfer
        r0 = rises[0];
        wr(0, 16'h81E7);
        wait_rises(0, r0, 5);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_dout", 0, dout[0], 16'h0000);
        check("arst_cs_n", 0, 16'(cs_n[0]), 16'h0001);
        check("arst_sck",  0, 16'(sck[0]),  16'h0000);
        check("arst_mosi", 0, 16'(mosi[0]), 16'h0000);
        tick(3);
        rst_n = 1'b1;
        r0 = rises[0];
        tick(100);
        check("arst_no_sck", 0, 16'(rises[0] - r0), 16'd0);
        check("arst_dout_after", 0, dout[0], 16'h0000);

        // CLK_DIV=1 loopback
        loop[1] = 1'b1;
        r1 = rises[1]; b0 = busy_cyc[1];
        wr(1, 16'h8100);
        wait_idle(1);
        tick(2);
        check("div1_rises", 1, 16'(rises[1] - r1), 16'd8);
        check("div1_busy_len", 1, 16'(busy_cyc[1] - b0), 16'd16);
        check("div1_gap", 1, 16'(last_gap[1]), 16'd2);
        check("div1_dout", 1, dout[1], 16'h4100);

        tick(5);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
